// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// One bit per cycle; stalls EX on HI/LO-dependent ops while busy.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             mf_req,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               div0;
    logic               neg_q;
    logic               neg_r;

    // op[0] clear means signed (MULT/DIV)
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign a_neg = ~op[0] & rs[WIDTH-1];
    assign b_neg = ~op[0] & rt[WIDTH-1];
    assign abs_a = a_neg ? -rs : rs;
    assign abs_b = b_neg ? -rt : rt;

    // Shift-add step: low half holds the multiplier, upper half the partial sum
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                             : {1'b0, acc[2*WIDTH-1:1]};

    // Restoring step on {rem,quot}; one extra bit keeps the shifted-out MSB
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_sh   = {acc, 1'b0};
    assign div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opb};
    assign div_next = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                    : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign prod = neg_q ? -acc : acc;
    assign quot = acc[WIDTH-1:0];
    assign rem  = acc[2*WIDTH-1:WIDTH];

    assign busy  = (state != IDLE);
    assign stall = busy & (start | mf_req | mt_hi | mt_lo);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (mt_hi) hi <= rs;
                        if (mt_lo) lo <= rs;
                        if (start) begin
                            is_div <= op[1];
                            cnt    <= '0;
                            opb    <= abs_b;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            if (op[1] && rt == '0) begin
                                div0  <= 1'b1;
                                acc   <= {{WIDTH{1'b0}}, rs};
                                state <= SIGN;
                            end else begin
                                div0  <= 1'b0;
                                acc   <= {{WIDTH{1'b0}}, abs_a};
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= SIGN;
                    end
                    SIGN: begin
                        state <= IDLE;
                        done  <= 1'b1;
                        if (div0) begin
                            hi <= acc[WIDTH-1:0];
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= neg_r ? -rem : rem;
                            lo <= neg_q ? -quot : quot;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases plus random ops against
// a 64-bit arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mf_req;
    logic        mt_hi;
    logic        mt_lo;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs(rs), .rt(rt), .mf_req(mf_req), .mt_hi(mt_hi),
        .mt_lo(mt_lo), .flush(flush), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        longint r;
        logic [63:0] p;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else p = {a % b, a / b};
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        int lat;
        int explat;
        model(o, a, b, eh, el);
        explat = (o[1] && b == 0) ? 1 : 33;
        start = 1'b1; op = o; rs = a; rt = b;
        tick();
        start = 1'b0; rs = $urandom; rt = $urandom;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 100);
        check({tag, "_lat"}, lat, explat);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int lat;
        int pulses;

        reset = 1'b0; start = 1'b0; op = 2'd0; rs = '0; rt = '0;
        mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; flush = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);

        run_op("mult", 2'd0, 32'hFFFF_FFFE, 32'd3);
        run_op("multu", 2'd1, 32'hFFFF_FFFE, 32'd3);
        run_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 2'd3, 32'd100, 32'd7);
        run_op("divu0", 2'd3, 32'd5, 32'd0);
        run_op("div0s", 2'd2, 32'h8000_0001, 32'd0);
        run_op("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("multmin", 2'd0, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            run_op("rand", o, a, b);
        end

        // MFHI/MFLO held from cycle 10 must stall until the done cycle
        a = $urandom;
        b = $urandom;
        model(2'd1, a, b, eh, el);
        start = 1'b1; op = 2'd1; rs = a; rt = b;
        tick();
        start = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat >= 10) mf_req = 1'b1;
            #1;
            if (!done && lat >= 10) check("hz_stall", stall, 1);
        end while (!done && lat < 100);
        check("hz_lat", lat, 33);
        check("hz_stall_done", stall, 0);
        check("hz_hi", hi, eh);
        check("hz_lo", lo, el);
        mf_req = 1'b0;

        // flush mid-divide leaves HI/LO alone and suppresses done
        mt_hi = 1'b1; rs = 32'h11;
        tick();
        mt_hi = 1'b0; mt_lo = 1'b1; rs = 32'h22;
        tick();
        mt_lo = 1'b0;
        check("mt_hi", hi, 32'h11);
        check("mt_lo", lo, 32'h22);
        start = 1'b1; op = 2'd2; rs = $urandom; rt = 32'd5;
        tick();
        start = 1'b0;
        repeat (14) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", busy, 0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        check("fl_done", pulses, 0);
        check("fl_hi", hi, 32'h11);
        check("fl_lo", lo, 32'h22);

        // simultaneous MTHI/MTLO in idle
        mt_hi = 1'b1; mt_lo = 1'b1; rs = 32'hA5A5_A5A5;
        #1;
        check("mt2_stall", stall, 0);
        tick();
        mt_hi = 1'b0; mt_lo = 1'b0;
        check("mt2_hi", hi, 32'hA5A5_A5A5);
        check("mt2_lo", lo, 32'hA5A5_A5A5);

        // MT while busy is held off and leaves registers unchanged
        start = 1'b1; op = 2'd0; rs = 32'd7; rt = 32'd9;
        tick();
        start = 1'b0;
        repeat (3) tick();
        mt_hi = 1'b1; mt_lo = 1'b1; rs = 32'h1234_5678;
        #1;
        check("mtb_stall", stall, 1);
        tick();
        check("mtb_hi", hi, 32'hA5A5_A5A5);
        check("mtb_lo", lo, 32'hA5A5_A5A5);
        mt_hi = 1'b0; mt_lo = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 100);
        check("mtb_done", done, 1);
        check("mtb_res_hi", hi, 32'd0);
        check("mtb_res_lo", lo, 32'd63);

        // reset mid-multiply
        start = 1'b1; op = 2'd0; rs = $urandom; rt = $urandom;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("mr_hi", hi, 0);
        check("mr_lo", lo, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_stall", stall, 0);
        reset = 1'b1;
        run_op("post_rst", 2'd3, 32'd1000, 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer beside the EX stage. It owns the HI/LO register pair and runs MULT/MULTU/DIV/DIVU one bit per cycle, off the single-cycle ALU path. It raises a stall to the pipeline whenever EX issues a HI/LO-dependent operation while a sequence is in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- start  input  1  EX requests a mul/div operation this cycle.
- op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs  input  WIDTH  operand A (multiplicand / dividend).
- rt  input  WIDTH  operand B (multiplier / divisor).
- mf_req  input  1  EX is executing MFHI/MFLO this cycle.
- mt_hi  input  1  MTHI write request; data taken from rs.
- mt_lo  input  1  MTLO write request; data taken from rs.
- flush  input  1  pipeline flush; cancels any in-flight sequence.
- hi  output  WIDTH  HI register (product[63:32] / remainder).
- lo  output  WIDTH  LO register (product[31:0] / quotient).
- busy  output  1  sequence in flight (state != IDLE).
- done  output  1  one-cycle pulse: HI/LO were just written by a completed sequence.
- stall  output  1  combinational; pipeline holds IF/ID/EX this cycle.

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: WIDTH iterations, counter 0..WIDTH-1.
  - SIGN: one cycle for sign fix-up and HI/LO writeback.
- IDLE→CALC: start=1, flush=0.
  - Latch |rs| and |rt|; absolute values only for the signed ops MULT/DIV.
  - Latch result_neg: rs[31]^rt[31] for MULT/DIV quotient; rs[31] for DIV remainder.
  - Clear the counter and the 2·WIDTH accumulator.
- CALC, multiply: radix-2 shift-add; per iteration, if multiplier LSB is set, add multiplicand to the upper half, then shift right by 1.
- CALC, divide: restoring divide; shift {rem,quot} left by 1, trial subtract the divisor, keep the result if non-negative and set the quotient bit.
- CALC→SIGN after the iteration where counter = WIDTH-1.
- SIGN→IDLE. The SIGN edge writes:
  - Multiply: {hi,lo} = product, two's-complement negated if result_neg.
  - Divide: lo = quotient, hi = remainder, each negated per its own sign flag.
- Divide by zero (rt=0), checked at start:
  - Skip CALC; go IDLE→SIGN directly.
  - SIGN writes lo=all-ones, hi=rs.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap; no trap).
- MTHI/MTLO while idle: write hi (or lo) = rs at the edge. Both asserted together: both written.
- stall = busy & (start | mf_req | mt_hi | mt_lo). Requests seen during busy are not accepted; EX holds and re-presents them.
- flush=1 at any edge:
  - state→IDLE and the counter clears; hi/lo are unchanged and done stays 0.
  - flush beats start and mt_* on the same edge.
- reset=0 at any edge: state=IDLE, hi=0, lo=0, done=0, counter=0. Takes effect mid-sequence too.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0. stall=0, since busy=0.
- start sampled at edge E0; busy=1 from after E0.
- CALC iterations occur at edges E1..E32. The SIGN edge is E33; it writes hi/lo, so done=1 and busy=0 in the cycle after E33.
- Total latency: 33 cycles start→done. The new hi/lo are visible on the outputs in the same cycle done is high.
- Divide by zero: SIGN edge is E1; done is high in the cycle after E1.
- A new start may be accepted in the cycle done is high; it is sampled at E34, back-to-back.
- MFHI/MFLO issued in the done cycle: no stall; it reads the new values.
- mt_* in IDLE: hi/lo update at that edge; zero latency, no stall.
- done is registered and high for exactly one cycle per completed sequence.

## Test plan
- Reset: hold reset=0 for 2 cycles, release → hi=0, lo=0, busy=0, done=0, stall=0.
- MULT rs=0xFFFFFFFE (−2), rt=3 → done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 100/7 → lo=14, hi=2. DIVU by 0 with rs=5 → lo=0xFFFFFFFF, hi=5, done 1 cycle after start.
- Hazard: start MULTU, then assert mf_req at cycle 10 → stall=1 through cycle 32, stall=0 in the done cycle, and hi/lo show the new result.
- Flush at cycle 15 of a DIV, with prior hi=0x11, lo=0x22 → busy=0 next cycle, done never pulses, hi=0x11, lo=0x22. reset=0 mid-MULT → all outputs reach their reset values at the next edge.
- mt_hi=mt_lo=1, rs=0xA5A5A5A5 in IDLE → hi=lo=0xA5A5A5A5 next cycle, no stall. Same request while busy → stall=1, registers unchanged.
